// File: rtl/waitstate_ram_responder_if.sv
// CPU data-memory handshake bundle shared by the CPU side and the wait-state RAM responder.
// The master drives the request and the responder returns data and status.
interface waitstate_ram_responder_if;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        read;
  logic        write;
  logic [15:0] data_out;
  logic        busy;
  logic        ready;
  logic        cack;

  modport master (
    output addr, data_in, read, write,
    input  data_out, busy, ready, cack
  );

  modport slave (
    input  addr, data_in, read, write,
    output data_out, busy, ready, cack
  );
endinterface

// File: rtl/waitstate_ram_responder.sv
// On-chip RAM responder for the I/O hole below 0x1000, with programmable wait states.
// It uses the same read/write/busy/ready/cack handshake as the SDRAM controller.
module waitstate_ram_responder #(
  parameter int ADDR_BITS   = 12,
  parameter int WAIT_STATES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  waitstate_ram_responder_if.slave  bus
);

  localparam int         DEPTH     = 1 << ADDR_BITS;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT    = 3'd1;
  localparam logic [2:0] ST_ACCESS  = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  logic [2:0]  state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [15:0] addr_reg, addr_next;
  logic [15:0] wdata_reg, wdata_next;
  logic        is_write_reg, is_write_next;
  logic        busy_reg, busy_next;
  logic        ready_reg, ready_next;
  logic        cack_reg, cack_next;
  logic [15:0] data_out_reg;

  logic [15:0]          mem [DEPTH];
  logic [ADDR_BITS-1:0] ram_idx;
  logic                 in_range;
  logic                 ram_we;
  logic                 ram_re;
  logic                 dout_clr;

  // Addresses at or above the RAM depth still handshake but never touch memory.
  assign in_range = (addr_reg >> ADDR_BITS) == 16'd0;
  assign ram_idx  = addr_reg[ADDR_BITS-1:0];
  assign ram_we   = !rst && (state_reg == ST_ACCESS) && is_write_reg && in_range;
  assign ram_re   = (state_reg == ST_ACCESS) && !is_write_reg;
  assign dout_clr = rst || (ram_re && !in_range);

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    is_write_next = is_write_reg;
    busy_next     = busy_reg;
    ready_next    = ready_reg;
    cack_next     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.read || bus.write) begin
          addr_next     = bus.addr;
          wdata_next    = bus.data_in;
          is_write_next = bus.write;
          cack_next     = 1'b1;
          busy_next     = 1'b1;
          ready_next    = 1'b0;
          if (WAIT_STATES == 0) begin
            state_next = ST_ACCESS;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_next = ST_DONE;
        busy_next  = 1'b0;
        ready_next = 1'b1;
      end
      ST_DONE: begin
        state_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        // A request still held from the finished op must drop before a new one is taken.
        if (!bus.read && !bus.write) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 4'd0;
      addr_reg     <= 16'd0;
      wdata_reg    <= 16'd0;
      is_write_reg <= 1'b0;
      busy_reg     <= 1'b0;
      ready_reg    <= 1'b1;
      cack_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      is_write_reg <= is_write_next;
      busy_reg     <= busy_next;
      ready_reg    <= ready_next;
      cack_reg     <= cack_next;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_idx] <= wdata_reg;
    end
  end

  // Read register doubles as data_out: the clear covers both reset and out-of-range reads.
  always_ff @(posedge clk) begin
    if (dout_clr) begin
      data_out_reg <= 16'd0;
    end else if (ram_re) begin
      data_out_reg <= mem[ram_idx];
    end
  end

  assign bus.data_out = data_out_reg;
  assign bus.busy     = busy_reg;
  assign bus.ready    = ready_reg;
  assign bus.cack     = cack_reg;

endmodule

// File: tb/tb_waitstate_ram_responder.sv
// Directed bench: one stimulus stream drives two responders (WAIT_STATES=2 and 0).
// Handshake status and read data of both are checked against hand-computed values.
module tb_waitstate_ram_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = 16'd0;
  logic [15:0] din = 16'd0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  int          checks = 0;
  int          passes = 0;

  waitstate_ram_responder_if b2 ();
  waitstate_ram_responder_if b0 ();

  assign b2.addr    = addr;
  assign b2.data_in = din;
  assign b2.read    = rd;
  assign b2.write   = wr;
  assign b0.addr    = addr;
  assign b0.data_in = din;
  assign b0.read    = rd;
  assign b0.write   = wr;

  waitstate_ram_responder #(.ADDR_BITS(12), .WAIT_STATES(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  waitstate_ram_responder #(.ADDR_BITS(12), .WAIT_STATES(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Status is packed as {busy, ready, cack}.
  task automatic chk_status(input string tag, input logic [2:0] exp2, input logic [2:0] exp0);
    chk({tag, " ws2 status"}, {13'd0, b2.busy, b2.ready, b2.cack}, {13'd0, exp2});
    chk({tag, " ws0 status"}, {13'd0, b0.busy, b0.ready, b0.cack}, {13'd0, exp0});
  endtask

  task automatic chk_dout(input string tag, input logic [15:0] exp);
    chk({tag, " ws2 data_out"}, b2.data_out, exp);
    chk({tag, " ws0 data_out"}, b0.data_out, exp);
  endtask

  // Called at a negedge with both DUTs idle; returns at a negedge with both idle again.
  task automatic op(input string name, input logic w, input logic r,
                    input logic [15:0] a, input logic [15:0] d, input int hold);
    logic [2:0] e2;
    logic [2:0] e0;
    wr = w; rd = r; addr = a; din = d;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      e2 = (k == 1) ? 3'b101 : ((k == 4) ? 3'b010 : 3'b100);
      e0 = (k == 1) ? 3'b101 : 3'b010;
      chk_status($sformatf("%s k%0d", name, k), e2, e0);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk_status($sformatf("%s hold%0d", name, h), 3'b010, 3'b010);
    end
    wr = 1'b0; rd = 1'b0;
    repeat ((hold == 0) ? 2 : 1) @(negedge clk);
    $display("op %s w=%b r=%b addr=%h din=%h -> ws2 data_out=%h ws0 data_out=%h",
             name, w, r, a, d, b2.data_out, b0.data_out);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_status("reset", 3'b010, 3'b010);
    chk_dout("reset", 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    op("wr 0010", 1'b1, 1'b0, 16'h0010, 16'hBEEF, 0);
    chk_dout("wr 0010", 16'h0000);
    op("rd 0010", 1'b0, 1'b1, 16'h0010, 16'h0000, 0);
    chk_dout("rd 0010", 16'hBEEF);

    op("rd 0010 held", 1'b0, 1'b1, 16'h0010, 16'h0000, 10);
    op("rd 0010 again", 1'b0, 1'b1, 16'h0010, 16'h0000, 0);
    chk_dout("rd 0010 again", 16'hBEEF);

    op("wr 0abc", 1'b1, 1'b0, 16'h0ABC, 16'h1234, 0);
    op("rd 0abc", 1'b0, 1'b1, 16'h0ABC, 16'h0000, 0);
    chk_dout("rd 0abc", 16'h1234);

    op("wr 0000", 1'b1, 1'b0, 16'h0000, 16'h1357, 0);
    op("wr 1000 oor", 1'b1, 1'b0, 16'h1000, 16'h5555, 0);
    chk_dout("wr 1000 oor", 16'h1234);
    op("rd 0000", 1'b0, 1'b1, 16'h0000, 16'h0000, 0);
    chk_dout("rd 0000", 16'h1357);
    op("rd 1000 oor", 1'b0, 1'b1, 16'h1000, 16'h0000, 0);
    chk_dout("rd 1000 oor", 16'h0000);

    op("wr 0020", 1'b1, 1'b0, 16'h0020, 16'hA5A5, 0);
    op("rd 0010 pre-rst", 1'b0, 1'b1, 16'h0010, 16'h0000, 0);
    chk_dout("rd 0010 pre-rst", 16'hBEEF);

    // ws2 is in WAIT and ws0 is in ACCESS when rst is sampled.
    wr = 1'b1; addr = 16'h0020; din = 16'h7777;
    @(negedge clk);
    chk_status("wr 0020 accepted", 3'b101, 3'b101);
    rst = 1'b1;
    @(negedge clk);
    chk_status("mid-op reset", 3'b010, 3'b010);
    chk_dout("mid-op reset", 16'h0000);
    rst = 1'b0; wr = 1'b0;
    @(negedge clk);
    $display("op mid-op reset during wr 0020=7777 -> ws2 data_out=%h ws0 data_out=%h",
             b2.data_out, b0.data_out);
    op("rd 0020", 1'b0, 1'b1, 16'h0020, 16'h0000, 0);
    chk_dout("rd 0020", 16'hA5A5);

    op("rw 0030", 1'b1, 1'b1, 16'h0030, 16'h00FF, 0);
    chk_dout("rw 0030", 16'hA5A5);
    op("rd 0030", 1'b0, 1'b1, 16'h0030, 16'h0000, 0);
    chk_dout("rd 0030", 16'h00FF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/waitstate_ram_responder.md
Name: waitstate_ram_responder

Overview:
- Bus responder for the CPU data-memory handshake (read/write strobes, busy/ready/cack) on the same side as the SDRAM controller.
- Backs the currently unused I/O hole below 0x1000 with an on-chip synchronous RAM.
- Programmable wait states let software and benches exercise the slow-memory path without SDRAM timing.
- Top-level decode gates read/write to this block and muxes its data_out, busy, ready and cack into the CPU bus.

Parameters:
- ADDR_BITS, 12, width of the word-addressed RAM (depth 2^ADDR_BITS x 16).
- WAIT_STATES, 2, extra cycles inserted before the RAM access (0..15).

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  reset; synchronous, active-high.
- addr  in  16  word address, already offset by top decode.
- data_in  in  16  write data.
- read  in  1  read request level, held by the CPU until ready.
- write  in  1  write request level, held by the CPU until ready.
- data_out  out  16  read data, registered.
- busy  out  1  operation in progress.
- ready  out  1  high when idle or when the op has completed. Low while an op is pending.
- cack  out  1  one-cycle pulse: command accepted.

Behaviour:
- Reset values: busy=0, ready=1, cack=0, data_out=0, state=IDLE, wait counter=0. RAM contents are not cleared.
- All outputs are registered. There is no combinational path from any input to any output.
- States: IDLE, WAIT, ACCESS, DONE, RELEASE.
- IDLE: a request is sampled at edge N when read|write=1.
  - Latch addr, data_in and op. write has priority if both strobes are high.
  - At N+1: cack=1 for exactly 1 cycle, busy=1, ready=0.
  - Next state is WAIT with counter=WAIT_STATES, or ACCESS directly if WAIT_STATES=0.
- WAIT: decrement the counter each cycle. Go to ACCESS after WAIT_STATES cycles. Latched values are frozen; input changes are ignored.
- ACCESS: exactly one RAM cycle.
  - Write: store the latched data.
  - Read: issue the RAM read.
  - Next state is DONE.
- DONE: busy=0, ready=1.
  - Read: data_out = RAM word, valid from this cycle.
  - Write: data_out unchanged.
  - Timing: ready rises at edge N+2+WAIT_STATES. With the default parameters that is 4 cycles after sampling.
  - Next state is RELEASE.
- RELEASE: wait until read=0 and write=0, then go to IDLE.
  - A request still held after completion is never re-executed.
  - A fresh request needs at least one cycle with both strobes low.
- data_out holds its last read value through RELEASE, IDLE and subsequent writes until the next read completes.
- Out of range (addr >= 2^ADDR_BITS):
  - The full handshake still runs with identical timing.
  - A write is dropped.
  - A read returns 0x0000.
- Reset mid-operation:
  - Immediately returns to IDLE with the reset values.
  - A pending write is discarded, including when rst coincides with ACCESS; rst has priority over the RAM write enable.
  - Requests present during rst are ignored.
  - After rst falls, a still-held request is accepted as new. The CPU is also reset, so this is benign.
- Simultaneous read and write: treated as a write, and data_out is unchanged.

Test Plan:
- WAIT_STATES=2: write addr 0x0010 with data 0xBEEF, holding write.
  - cack pulses at N+1 for 1 cycle.
  - busy=1 during N+1..N+3.
  - ready=1 at N+4.
  - Drop write, then read 0x0010: data_out=0xBEEF at N+4.
- WAIT_STATES=0: back-to-back write and read of 0x0ABC/0x1234 with one idle cycle between. Each completes with ready at N+2, and the read returns 0x1234.
- Hold read high for 10 cycles after ready: exactly one cack pulse and busy stays 0. Drop read for 1 cycle, re-raise it: a second cack occurs.
- Out-of-range address with ADDR_BITS=12:
  - Write 0x1000 with 0x5555: completes normally, and a later read of 0x0000 returns its prior value (not 0x5555).
  - Read 0x1000: returns 0x0000.
- Assert rst for 1 cycle while in WAIT during a write of 0x7777 to 0x0020.
  - Outputs return to the reset values the next cycle.
  - A later read of 0x0020 returns the old content, not 0x7777.
- read and write both high on address 0x0030 with data 0x00FF: memory is written to 0x00FF and data_out keeps its previous value.
